// File: rtl/mmio_spi_core.sv
// SPI master slot core: one byte per transfer, MSB first, with programmable
// CPOL/CPHA and half-period divider, plus S software-driven slave selects.
module mmio_spi_core #(
    parameter int S = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic          spi_sclk,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic [S-1:0]  spi_ss_n
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CPHA_DLY = 2'd1;
    localparam logic [1:0] P0       = 2'd2;
    localparam logic [1:0] P1       = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [15:0]  c_q, c_d;
    logic [2:0]   n_q, n_d;
    logic [7:0]   tx_shift_q, tx_shift_d;
    logic [7:0]   rx_shift_q, rx_shift_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic [S-1:0] ss_reg_q, ss_reg_d;
    logic [15:0]  dvsr_q, dvsr_d;
    logic         cpol_q, cpol_d;
    logic         cpha_q, cpha_d;
    logic         sclk_q, sclk_d;
    logic         wr_en_s;
    logic         active_s;
    logic         unused_s;

    assign wr_en_s  = cs && write;
    assign unused_s = ^{read, addr[4:2], wr_data[31:18]};

    // Register writes, transfer FSM and next SCLK level.
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        n_d        = n_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        ss_reg_d   = ss_reg_q;
        dvsr_d     = dvsr_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;

        if (wr_en_s && addr[1:0] == 2'd1) begin
            ss_reg_d = wr_data[S-1:0];
        end else begin
            ss_reg_d = ss_reg_q;
        end

        case (state_q)
            IDLE: begin
                c_d = 16'd0;
                n_d = 3'd0;
                if (wr_en_s && addr[1:0] == 2'd2) begin
                    tx_shift_d = wr_data[7:0];
                    state_d    = cpha_q ? CPHA_DLY : P0;
                end else if (wr_en_s && addr[1:0] == 2'd3) begin
                    dvsr_d = wr_data[15:0];
                    cpol_d = wr_data[16];
                    cpha_d = wr_data[17];
                end else begin
                    state_d = IDLE;
                end
            end
            CPHA_DLY: begin
                if (c_q == dvsr_q) begin
                    c_d     = 16'd0;
                    state_d = P0;
                end else begin
                    c_d = c_q + 16'd1;
                end
            end
            P0: begin
                if (c_q == dvsr_q) begin
                    rx_shift_d = {rx_shift_q[6:0], spi_miso};
                    c_d        = 16'd0;
                    state_d    = P1;
                end else begin
                    c_d = c_q + 16'd1;
                end
            end
            P1: begin
                if (c_q == dvsr_q) begin
                    if (n_q == 3'd7) begin
                        rx_data_d = rx_shift_q;
                        state_d   = IDLE;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        n_d        = n_q + 3'd1;
                        c_d        = 16'd0;
                        state_d    = P0;
                    end
                end else begin
                    c_d = c_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // SCLK follows the state being entered so it lines up with MOSI changes.
        active_s = (state_d == P1 && !cpha_q) || (state_d == P0 && cpha_q);
        sclk_d   = cpol_q ^ active_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            c_q        <= 16'd0;
            n_q        <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            ss_reg_q   <= {S{1'b1}};
            dvsr_q     <= 16'd0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            n_q        <= n_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            ss_reg_q   <= ss_reg_d;
            dvsr_q     <= dvsr_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
        end
    end

    assign rd_data  = {23'd0, (state_q == IDLE), rx_data_q};
    assign spi_sclk = sclk_q;
    assign spi_mosi = tx_shift_q[7];
    assign spi_ss_n = ss_reg_q;

endmodule
